// File: rtl/led_drv_pkg.sv
// rtl/led_drv_pkg.sv - shared types and width helpers for the user LED driver
package led_drv_pkg;

  // Per-LED mode, 2 bits per LED on led_mode
  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_LEVEL   = 2'b01,
    LED_BLINK   = 2'b10,
    LED_STRETCH = 2'b11
  } led_mode_e;

  // Clock cycles per time-base tick
  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to hold 0..max_val, never less than one
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/user_led_driver_if.sv
// rtl/user_led_driver_if.sv - status-source and board-pin bundle for the LED driver
interface user_led_driver_if #(
  parameter int N_LED    = 4,
  parameter int PWM_BITS = 8
);
  logic [N_LED-1:0]    led_src;
  logic [2*N_LED-1:0]  led_mode;
  logic [PWM_BITS-1:0] brightness;
  logic [N_LED-1:0]    USER_LED;
  logic                tick_1ms;

  // Status side: drives sources, modes and brightness, watches the pins
  modport master (
    output led_src, led_mode, brightness,
    input  USER_LED, tick_1ms
  );

  // Driver side
  modport slave (
    input  led_src, led_mode, brightness,
    output USER_LED, tick_1ms
  );
endinterface

// File: rtl/led_pulse_stretch.sv
// rtl/led_pulse_stretch.sv - rising-edge detect with reloadable tick down-counter
module led_pulse_stretch
  import led_drv_pkg::*;
#(
  parameter int STRETCH_MS = 50
) (
  input  logic clk_in,
  input  logic rst,
  input  logic src_sync,
  input  logic tick,
  output logic act
);

  localparam int CNT_W = cnt_width(STRETCH_MS);

  logic             src_d;
  logic [CNT_W-1:0] cnt;
  logic             edge_det;

  assign edge_det = src_sync & ~src_d;
  assign act      = (cnt != '0);

  // A fresh edge always reloads, even on a tick cycle or while already active
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      src_d <= 1'b0;
      cnt   <= '0;
    end else begin
      src_d <= src_sync;
      if (edge_det)
        cnt <= CNT_W'(STRETCH_MS);
      else if (tick && (cnt != '0))
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/user_led_driver.sv
// rtl/user_led_driver.sv - per-LED mode select, time base, PWM dimming and pin register
module user_led_driver
  import led_drv_pkg::*;
#(
  parameter int N_LED        = 4,
  parameter int CLK_HZ       = 250_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int HEARTBEAT_MS = 500,
  parameter int STRETCH_MS   = 50,
  parameter int PWM_BITS     = 8
) (
  input  logic        clk_in,
  input  logic        rst,
  user_led_driver_if.slave bus
);

  localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int PRE_W    = cnt_width(TICK_DIV - 1);
  localparam int HB_W     = cnt_width(HEARTBEAT_MS - 1);

  if (CLK_HZ % TICK_HZ != 0) begin : g_bad_tick_div
    $error("CLK_HZ must be an exact multiple of TICK_HZ");
  end
  if (STRETCH_MS < 1) begin : g_bad_stretch
    $error("STRETCH_MS must be at least 1");
  end

  logic [PRE_W-1:0]    pre_cnt;
  logic                tick;
  logic [HB_W-1:0]     hb_cnt;
  logic                hb;
  logic [N_LED-1:0]    s1;
  logic [N_LED-1:0]    s2;
  logic [N_LED-1:0]    act;
  logic [N_LED-1:0]    sel;
  logic [PWM_BITS-1:0] pcnt;
  logic [PWM_BITS-1:0] bri_q;
  logic                pwm_on;

  assign tick         = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign bus.tick_1ms = tick;

  // Time-base prescaler: terminal count is the tick cycle
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      pre_cnt <= '0;
    else if (tick)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + 1'b1;
  end

  // Heartbeat: toggle every HEARTBEAT_MS ticks
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (tick) begin
      if (hb_cnt == HB_W'(HEARTBEAT_MS - 1)) begin
        hb_cnt <= '0;
        hb     <= ~hb;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous status sources
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.led_src;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_stretch
    led_pulse_stretch #(
      .STRETCH_MS(STRETCH_MS)
    ) u_stretch (
      .clk_in  (clk_in),
      .rst     (rst),
      .src_sync(s2[i]),
      .tick    (tick),
      .act     (act[i])
    );
  end

  // Per-LED source select; counters keep running regardless of mode
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (led_mode_e'(bus.led_mode[2*i +: 2]))
        LED_OFF:     sel[i] = 1'b0;
        LED_LEVEL:   sel[i] = s2[i];
        LED_BLINK:   sel[i] = hb;
        LED_STRETCH: sel[i] = act[i];
        default:     sel[i] = 1'b0;
      endcase
    end
  end

  // Free-running PWM counter; brightness only sampled at period start to avoid glitchy duty
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pcnt  <= '0;
      bri_q <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
      if (pcnt == '1)
        bri_q <= bus.brightness;
    end
  end

  assign pwm_on = (pcnt < bri_q);

  // Registered pin drive
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      bus.USER_LED <= '0;
    else
      bus.USER_LED <= sel & {N_LED{pwm_on}};
  end

endmodule
